// File: rtl/serial_bit_tx_pkg.sv
// serial_pkg: shared definitions for the serial bit transmitter.
//   - state_t: 2-bit FSM state (IDLE=00, SHIFT=01, DONE=10, 11 illegal)
//   - clog2(): constant helper used to size the bit counter
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10,
        ST_ILL   = 2'b11
    } state_t;

    // Ceiling log2, minimum 1 so a counter always has at least one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_bit_tx_if.sv
// serial_bit_tx_if: word-load / serial-bit bus of the transmitter.
//   load, din           : word request from the producer (master -> slave)
//   busy, x, x_valid,   : serial stream and status from the transmitter
//   done                  (slave -> master)
interface serial_bit_tx_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             x;
    logic             x_valid;
    logic             done;

    modport master (output load, din, input busy, x, x_valid, done);
    modport slave  (input load, din, output busy, x, x_valid, done);
endinterface

// File: rtl/serial_bit_tx_jk_ff.sv
// jk_ff: JK flip-flop, asynchronous active-high reset to 0.
//   Q out; J, K, clk, rst in.  Q+ = J&~Q | ~K&Q
module jk_ff (
    output logic Q,
    input  logic J,
    input  logic K,
    input  logic clk,
    input  logic rst
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) Q <= 1'b0;
        else     Q <= (J & ~Q) | (~K & Q);
    end
endmodule

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: loads a parallel word on bus.load and shifts it out on
// bus.x one bit per clk, qualified by bus.x_valid, followed by a one-cycle
// bus.done pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_bit_tx_if.slave (load, din in; busy, x, x_valid, done out)
module serial_bit_tx
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    serial_bit_tx_if.slave  bus
);
    localparam int CW = clog2(WIDTH);

    state_t           w_state;
    logic             w_q0, w_q1;
    logic             w_j0, w_k0, w_j1, w_k1;
    logic             w_last;
    logic             w_accept;
    logic             w_busy, w_x, w_done;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;

    // State register: one JK flop per state bit.
    jk_ff u_s0 (.Q(w_q0), .J(w_j0), .K(w_k0), .clk(clk), .rst(rst));
    jk_ff u_s1 (.Q(w_q1), .J(w_j1), .K(w_k1), .clk(clk), .rst(rst));

    assign w_state = state_t'({w_q1, w_q0});
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    // Next-state as JK excitation, from the transition table:
    //   s0+ : 00->load, 01->~last, 10->load, 11->0
    //   s1+ : 01->last, all others 0
    // J0 covers s0=0 rows (load), K0 clears s0 on last or from 11,
    // J1 sets s1 only from 01 on last, K1=1 so DONE/11 never persist.
    always_comb begin
        w_j0     = bus.load;
        w_k0     = w_last | w_q1;
        w_j1     = w_q0 & w_last;
        w_k1     = 1'b1;
        w_accept = 1'b0;
        w_busy   = 1'b0;
        w_x      = 1'b0;
        w_done   = 1'b0;
        case (w_state)
            ST_IDLE:  w_accept = bus.load;
            ST_SHIFT: begin
                w_busy = 1'b1;
                w_x    = LSB_FIRST ? r_sh[0] : r_sh[WIDTH-1];
            end
            ST_DONE: begin
                w_done   = 1'b1;
                w_accept = bus.load;
            end
            default: ;
        endcase
    end

    // Shift register and bit counter; the counter is cleared on the last
    // bit so it never reaches WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_sh  <= bus.din;
            r_cnt <= '0;
        end else if (w_state == ST_SHIFT) begin
            r_sh  <= LSB_FIRST ? (r_sh >> 1) : (r_sh << 1);
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign bus.busy    = w_busy;
    assign bus.x_valid = w_busy;
    assign bus.x       = w_x;
    assign bus.done    = w_done;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: an LSB-first and an MSB-first instance
// share load/din; a per-cycle vector table covers single words, load while
// busy and back-to-back words; hand sequences cover reset mid-word and a
// "101" detector fed from the serial stream.
module tb_serial_bit_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] din;

    always #5 clk = ~clk;

    serial_bit_tx_if #(.WIDTH(8)) bl ();
    serial_bit_tx_if #(.WIDTH(8)) bm ();

    assign bl.load = load;
    assign bl.din  = din;
    assign bm.load = load;
    assign bm.din  = din;

    serial_bit_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst(rst), .bus(bl));
    serial_bit_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .bus(bm));

    // Overlapping "101" detector on the gated LSB-first stream.
    logic [1:0] r_hist;
    logic       r_det;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_det  <= 1'b0;
        end else if (bl.x_valid) begin
            r_hist <= {r_hist[0], bl.x & bl.x_valid};
            r_det  <= ({r_hist, bl.x & bl.x_valid} == 3'b101);
        end else begin
            r_hist <= '0;
            r_det  <= 1'b0;
        end
    end

    typedef struct packed {
        logic       ld;
        logic [7:0] din;
        logic       busy;
        logic       xv;
        logic       done;
        logic       xl;
        logic       xm;
    } vec_t;

    vec_t tv[$];
    int   n_err = 0;
    int   n_chk = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic ld, input logic [7:0] d, input logic b,
                        input logic v, input logic dn, input logic xl, input logic xm);
        vec_t r;
        r.ld = ld; r.din = d; r.busy = b; r.xv = v; r.done = dn; r.xl = xl; r.xm = xm;
        tv.push_back(r);
    endtask

    // Eight SHIFT cycles; sl/sm give the bits in transmit order, MSB of the
    // literal first. pidx selects one bit cycle where load pulses with pdin.
    task automatic burst(input logic [7:0] sl, input logic [7:0] sm, input logic ld,
                         input logic [7:0] d, input int pidx, input logic [7:0] pdin);
        for (int b = 0; b < 8; b++) begin
            if (b == pidx) push(1'b1, pdin, 1'b1, 1'b1, 1'b0, sl[7-b], sm[7-b]);
            else           push(ld,   d,    1'b1, 1'b1, 1'b0, sl[7-b], sm[7-b]);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " lsb.busy"}, bl.busy, 1'b0);
        chk({tag, " lsb.xv"},   bl.x_valid, 1'b0);
        chk({tag, " lsb.x"},    bl.x, 1'b0);
        chk({tag, " lsb.done"}, bl.done, 1'b0);
        chk({tag, " msb.busy"}, bm.busy, 1'b0);
        chk({tag, " msb.xv"},   bm.x_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] det_exp;
        rst = 1'b1; load = 1'b0; din = 8'h00;

        // A5 single word
        push(1'b1, 8'hA5, 0, 0, 0, 0, 0);
        burst(8'b1010_0101, 8'b1010_0101, 1'b0, 8'h00, 8, 8'h00);
        push(1'b0, 8'h00, 0, 0, 1, 0, 0);
        push(1'b0, 8'h00, 0, 0, 0, 0, 0);
        // 0F with a load/F0 pulse during bit 4 that must be ignored
        push(1'b1, 8'h0F, 0, 0, 0, 0, 0);
        burst(8'b1111_0000, 8'b0000_1111, 1'b0, 8'h00, 3, 8'hF0);
        push(1'b0, 8'h00, 0, 0, 1, 0, 0);
        push(1'b0, 8'h00, 0, 0, 0, 0, 0);
        // back-to-back: 81 then 3C, load held high; din changes mid-word
        push(1'b1, 8'h81, 0, 0, 0, 0, 0);
        burst(8'b1000_0001, 8'b1000_0001, 1'b1, 8'h3C, 8, 8'h00);
        push(1'b1, 8'h3C, 0, 0, 1, 0, 0);
        burst(8'b0011_1100, 8'b0011_1100, 1'b1, 8'h3C, 8, 8'h00);
        push(1'b0, 8'h00, 0, 0, 1, 0, 0);
        push(1'b0, 8'h00, 0, 0, 0, 0, 0);
        push(1'b0, 8'h00, 0, 0, 0, 0, 0);

        @(negedge clk);
        chk_idle("reset");
        chk("reset det", r_det, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            chk($sformatf("v%0d lsb.busy", i), bl.busy,    tv[i].busy);
            chk($sformatf("v%0d lsb.xv",   i), bl.x_valid, tv[i].xv);
            chk($sformatf("v%0d lsb.done", i), bl.done,    tv[i].done);
            chk($sformatf("v%0d lsb.x",    i), bl.x,       tv[i].xl);
            chk($sformatf("v%0d msb.busy", i), bm.busy,    tv[i].busy);
            chk($sformatf("v%0d msb.xv",   i), bm.x_valid, tv[i].xv);
            chk($sformatf("v%0d msb.done", i), bm.done,    tv[i].done);
            chk($sformatf("v%0d msb.x",    i), bm.x,       tv[i].xm);
            load = tv[i].ld;
            din  = tv[i].din;
            @(negedge clk);
        end

        // Reset mid-word: after bits 1..3, assert rst without a clock edge.
        load = 1'b1; din = 8'hA5;
        @(negedge clk);
        load = 1'b0; din = 8'h00;
        chk("rmw bit1 x", bl.x, 1'b1);
        @(negedge clk);
        chk("rmw bit2 x", bl.x, 1'b0);
        @(negedge clk);
        chk("rmw bit3 x", bl.x, 1'b1);
        @(negedge clk);
        chk("rmw bit4 xv", bl.x_valid, 1'b1);
        #2 rst = 1'b1;
        #1 chk_idle("rmw async");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_idle($sformatf("rmw hold%0d", c));
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle($sformatf("rmw after%0d", c));
        end

        // Detector loopback: A5 LSB-first holds "101" ending at bits 3 and 8,
        // so the registered detector is high in cycles N+4 and N+9.
        det_exp = 11'b000_0010_0010 << 3;
        load = 1'b1; din = 8'hA5;
        @(negedge clk);
        load = 1'b0; din = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("det cyc%0d", k), r_det, (k == 4) || (k == 9));
            @(negedge clk);
        end
        chk("det mask", det_exp[4], 1'b1 ^ r_det);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_bit_tx.md
Name: serial_bit_tx

Overview:
- Serial bit-stream transmitter for the one-bit sequence-detector interface: single data bit x, one bit per clk.
- Accepts a parallel word on a load strobe and shifts it out serially on x, one bit per rising clk edge, with x_valid qualifying each bit.
- Drives the x input of the detector FSMs in the lab designs from stored test words, so detectors can be exercised in-system without a bench.

Parameters:
- WIDTH, 8, number of bits per word; legal range 2..32.
- LSB_FIRST, 1, 1 = din[0] transmitted first, 0 = din[WIDTH-1] transmitted first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  request to start transmitting din; sampled on rising clk.
- din  input  WIDTH  word to transmit; captured in the cycle load is accepted.
- busy  output  1  high while a word is being shifted (state SHIFT).
- x  output  1  serial data bit; forced 0 when x_valid is low.
- x_valid  output  1  high for exactly WIDTH consecutive cycles per word.
- done  output  1  one-cycle pulse after the last bit of a word.

Behaviour:
- Reset (rst=1, asynchronous, no clk needed):
  - state returns to IDLE; shift register and bit counter cleared.
  - busy=0, x=0, x_valid=0, done=0.
  - Holds while rst=1. A reset during SHIFT discards the partial word: no done pulse, x_valid drops immediately.
- State machine: 2-bit encoding IDLE=00, SHIFT=01, DONE=10; 11 is illegal and returns to IDLE on the next edge.
- IDLE:
  - load=1 at edge -> capture din into the shift register, clear the counter, go to SHIFT.
  - load=0 -> stay.
- SHIFT:
  - x = current output bit of the shift register (LSB or MSB per LSB_FIRST); x_valid=1; busy=1.
  - Each edge: shift one position (zero fill), counter += 1.
  - When counter = WIDTH-1 at an edge -> go to DONE.
  - load is ignored throughout SHIFT; din is not re-sampled.
- DONE:
  - Lasts exactly one cycle: done=1, x=0, x_valid=0, busy=0.
  - load=1 at that edge -> capture din and go to SHIFT (back-to-back words, one-cycle gap). Otherwise go to IDLE.
- Latency:
  - load accepted at edge N -> first bit valid during cycle N+1.
  - Last bit during cycle N+WIDTH; done during cycle N+WIDTH+1.
- All outputs are registered-state decodes (Moore). No combinational path from load or din to any output.
- Counter width: clog2(WIDTH). It never exceeds WIDTH-1, so no wrap occurs inside SHIFT.
- load held high continuously: words are sent back-to-back with the one-cycle DONE gap. din is sampled only in IDLE/DONE accept cycles.

Decomposition:
- Shared package serial_pkg holds:
  - state encoding constants ST_IDLE, ST_SHIFT, ST_DONE;
  - a 2-bit state typedef;
  - the clog2 helper for counter width.
- One sub-module, jk_ff: JK flip-flop with asynchronous active-high reset to 0. Ports: Q out; J, K, clk, rst in. Next-state logic Q+ = J·~Q + ~K·Q.
- The two state bits are built from jk_ff instances, with J/K equations derived from the transition list above.
- The shift register and counter are plain registers in the top module.

Test Plan:
- Reset mid-word: WIDTH=8, load din=8'hA5, assert rst after 3 bits -> x_valid, x and busy go 0 without a clk edge; no done pulse; after release, stays IDLE with outputs 0.
- Basic LSB-first: load din=8'hA5 at edge N -> x over cycles N+1..N+8 = 1,0,1,0,0,1,0,1; x_valid=1 for exactly those 8 cycles; done=1 only in cycle N+9.
- MSB-first: LSB_FIRST=0, din=8'hA5 -> x sequence 1,0,1,0,0,1,0,1 reversed order of bits = 1,0,1,0,0,1,0,1 (check with din=8'h0F: 0,0,0,0,1,1,1,1).
- Load ignored while busy: load din=8'h0F, then pulse load with din=8'hF0 during bit 4 -> transmitted word stays 8'h0F; returns to IDLE after done.
- Back-to-back: load held high with din=8'h81 then 8'h3C -> two 8-bit bursts separated by exactly one DONE cycle; the second burst is 8'h3C, sampled at the DONE edge.
- Detector loopback: connect x (gated by x_valid) to a sequence-detector instance, send a word containing the target pattern -> detector output asserts at the expected bit cycle.
